// File: rtl/fproc_meas_arb.sv
// fproc_meas_arb: round-robin arbiter that lets N_CORES cores share one
// function-processor/measurement lookup port. Each core posts a one-cycle
// request. The request is held pending until it is granted, issued
// downstream and completed, either by fp_ready or by the WAIT timeout.
module fproc_meas_arb #(
  parameter int N_CORES    = 5,
  parameter int ID_WIDTH   = 8,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 1024
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [N_CORES-1:0]            core_enable,
  input  logic [N_CORES*ID_WIDTH-1:0]   core_id,
  output logic [N_CORES-1:0]            core_ready,
  output logic [N_CORES*DATA_WIDTH-1:0] core_data,
  output logic                          fp_enable,
  output logic [ID_WIDTH-1:0]           fp_id,
  input  logic                          fp_ready,
  input  logic [DATA_WIDTH-1:0]         fp_data,
  output logic                          busy,
  output logic                          timeout_err
);

  localparam int IDX_W = (N_CORES > 1) ? $clog2(N_CORES) : 1;
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_CORES - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT} state_e;

  state_e                        state_q, state_d;
  logic [N_CORES-1:0]            pending_q, pending_d;
  logic [ID_WIDTH-1:0]           id_q [N_CORES];
  logic [ID_WIDTH-1:0]           id_d [N_CORES];
  logic [IDX_W-1:0]              rr_q, rr_d;
  logic [IDX_W-1:0]              gnt_q, gnt_d;
  logic [CNT_W-1:0]              cnt_q, cnt_d;

  logic [N_CORES-1:0]            core_ready_q, core_ready_d;
  logic [N_CORES*DATA_WIDTH-1:0] core_data_q, core_data_d;
  logic                          fp_enable_q, fp_enable_d;
  logic [ID_WIDTH-1:0]           fp_id_q, fp_id_d;
  logic                          busy_q, busy_d;
  logic                          timeout_err_q, timeout_err_d;

  logic                          srch_found;
  logic [IDX_W-1:0]              srch_idx;
  logic [IDX_W-1:0]              cand;
  logic                          done;
  logic [DATA_WIDTH-1:0]         done_data;

  // Round-robin search: first pending core at or above rr_q, wrapping mod N_CORES.
  always_comb begin
    // NOTE: every variable written here is given a default first, so no latch is inferred.
    srch_found = 1'b0;
    srch_idx   = '0;
    cand       = '0;
    for (int k = 0; k < N_CORES; k++) begin
      cand = IDX_W'((int'(rr_q) + k) % N_CORES);
      if (!srch_found && pending_q[cand]) begin
        srch_found = 1'b1;
        srch_idx   = cand;
      end
    end
  end

  // Transaction FSM: next state plus next values of the registered outputs.
  always_comb begin
    state_d       = state_q;
    gnt_d         = gnt_q;
    rr_d          = rr_q;
    cnt_d         = cnt_q;
    done          = 1'b0;
    done_data     = '0;
    fp_enable_d   = 1'b0;
    fp_id_d       = fp_id_q;
    core_ready_d  = '0;
    core_data_d   = core_data_q;
    timeout_err_d = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (srch_found) begin
          gnt_d       = srch_idx;
          fp_enable_d = 1'b1;
          fp_id_d     = id_q[srch_idx];
          state_d     = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        cnt_d   = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        // A late fp_ready that lands on the timeout cycle still counts as a normal completion.
        if (fp_ready) begin
          done      = 1'b1;
          done_data = fp_data;
        end else if (cnt_q == CNT_LAST) begin
          done          = 1'b1;
          timeout_err_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (done) begin
      state_d = ST_IDLE;
      rr_d    = (gnt_q == IDX_LAST) ? '0 : gnt_q + 1'b1;
      for (int i = 0; i < N_CORES; i++) begin
        if (gnt_q == IDX_W'(i)) begin
          core_ready_d[i]                            = 1'b1;
          core_data_d[i*DATA_WIDTH +: DATA_WIDTH] = done_data;
        end
      end
    end

    busy_d = (state_d != ST_IDLE);
  end

  // Pending bits and latched ids; a new enable wins over the completion clearing the same core.
  always_comb begin
    pending_d = pending_q;
    id_d      = id_q;
    for (int i = 0; i < N_CORES; i++) begin
      logic clr;
      clr          = done && (gnt_q == IDX_W'(i));
      pending_d[i] = core_enable[i] | (pending_q[i] & ~clr);
      if (core_enable[i] && (!pending_q[i] || clr)) begin
        id_d[i] = core_id[i*ID_WIDTH +: ID_WIDTH];
      end
    end
  end

  // Control and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= ST_IDLE;
      pending_q     <= '0;
      rr_q          <= '0;
      gnt_q         <= '0;
      cnt_q         <= '0;
      core_ready_q  <= '0;
      core_data_q   <= '0;
      fp_enable_q   <= 1'b0;
      fp_id_q       <= '0;
      busy_q        <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q       <= state_d;
      pending_q     <= pending_d;
      rr_q          <= rr_d;
      gnt_q         <= gnt_d;
      cnt_q         <= cnt_d;
      core_ready_q  <= core_ready_d;
      core_data_q   <= core_data_d;
      fp_enable_q   <= fp_enable_d;
      fp_id_q       <= fp_id_d;
      busy_q        <= busy_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  // Latched request ids.
  // NOTE: the id storage has no reset; an entry is only read while its pending bit is set.
  always_ff @(posedge clk) begin
    id_q <= id_d;
  end

  assign core_ready  = core_ready_q;
  assign core_data   = core_data_q;
  assign fp_enable   = fp_enable_q;
  assign fp_id       = fp_id_q;
  assign busy        = busy_q;
  assign timeout_err = timeout_err_q;

endmodule

// File: doc/fproc_meas_arb.md
# fproc_meas_arb

Round-robin arbiter that lets N_CORES processor cores share a single function-processor/measurement lookup port. Each core issues a one-cycle request (enable + id); the block latches it as pending, grants one requester at a time, issues it on the shared downstream port, waits for that port's ready, and returns the result on the granted core's ready/data. A per-transaction timeout keeps a core from stalling forever if the addressed measurement never becomes valid. Sits between the core-side fproc channels and the shared measurement fproc block.

## Interface
- N_CORES, 5, number of requesting cores
- ID_WIDTH, 8, width of request id
- DATA_WIDTH, 32, width of returned data
- TIMEOUT, 1024, max cycles in WAIT before forced completion (must be ≥2)

- clk  in  1  system clock
- reset  in  1  synchronous, active-low reset
- core_enable  in  N_CORES  per-core request pulse
- core_id  in  N_CORES*ID_WIDTH  per-core request id, core i at bits [i*ID_WIDTH +: ID_WIDTH]
- core_ready  out  N_CORES  per-core one-cycle completion pulse
- core_data  out  N_CORES*DATA_WIDTH  per-core result, same packing as core_id
- fp_enable  out  1  downstream request pulse
- fp_id  out  ID_WIDTH  downstream request id
- fp_ready  in  1  downstream completion
- fp_data  in  DATA_WIDTH  downstream result, valid with fp_ready
- busy  out  1  high whenever state ≠ IDLE
- timeout_err  out  1  one-cycle pulse on forced completion

## Operation
- Per core: pending bit plus latched id. core_enable[i] high sets pending[i] and captures core_id[i] at the clock edge.
- core_enable[i] while pending[i] already set and not being cleared this cycle: ignored (id not overwritten).
- Set wins over clear: enable on the cycle pending[i] clears starts a new pending request with the new id.
- State machine: IDLE, ISSUE, WAIT.
  - IDLE: if any pending, grant g = first pending index searching from rr_ptr upward mod N_CORES; register g and latched id; next ISSUE. Else stay.
  - ISSUE: fp_enable=1, fp_id=latched id of g, exactly one cycle; clear timeout counter; next WAIT.
  - WAIT: counter increments each cycle. On fp_ready: capture fp_data into core_data[g], clear pending[g], rr_ptr ← (g+1) mod N_CORES, next IDLE. On counter = TIMEOUT-1 with fp_ready low: same completion but core_data[g] ← 0 and timeout_err pulse.
- fp_ready and timeout in the same cycle: treated as normal completion, no timeout_err.
- fp_ready while IDLE or ISSUE: ignored (stray completion from an aborted transaction).
- core_data[i] holds its last value until that core's next completion.
- Timeout counter width $clog2(TIMEOUT+1); never wraps (reset on each ISSUE).
- Reset (reset=0 at a clock edge): all pending cleared, state IDLE, rr_ptr=0, g=0; requests in flight are discarded, no ready issued for them.

## Timing
- All outputs registered. Reset values: core_ready=0, core_data=0, fp_enable=0, fp_id=0, busy=0, timeout_err=0.
- core_enable in cycle 0 → pending in cycle 1 → grant (IDLE) cycle 1 → fp_enable cycle 2 → earliest fp_ready cycle 3 → core_ready[g] pulse cycle 4, with core_data[g] valid the same cycle.
- fp_ready sampled in cycle k → core_ready[g] high in cycle k+1 only; state IDLE in k+1; next grant evaluated in k+1, next fp_enable in k+2.
- Timeout: fp_enable in cycle c, no fp_ready → core_ready[g] and timeout_err high in cycle c+TIMEOUT+1.
- Back-to-back throughput: one transaction per 3 cycles plus downstream latency.
- At most one core_ready bit high in any cycle.

## Test plan
- Single request: core 2 enable, id=7, fp_ready 5 cycles after fp_enable with fp_data=1 → fp_id=7 one cycle, core_ready[2] pulse with core_data[2]=1, all other core_ready low.
- Fairness: cores 0,1,4 enable same cycle, fp_ready returns immediately → fp_enable order 0,1,4; then cores 0 and 4 re-request while 1 in flight → order continues 4 then 0.
- Duplicate/set-wins: core 3 re-enables with id=9 while pending id=5 → issued id=5; re-enable with id=9 on completion cycle → second transaction issues id=9.
- Timeout with TIMEOUT=8: fp_ready never asserted → core_ready[g] and timeout_err in cycle fp_enable+9, core_data[g]=0; fp_ready at counter = TIMEOUT-1 → normal completion, timeout_err stays low.
- Stray ready: fp_ready pulsed while IDLE → no core_ready, no state change.
- Reset mid-WAIT: reset low one cycle → busy=0, all outputs 0, no core_ready for the aborted request; new request afterward completes normally with rr_ptr starting at 0.
